bw_seq_mult: RTL and testbench

//   Iterative signed Baugh-Wooley multiplier. Adds one partial-product row per clock.

---
 rtl/bw_seq_mult.sv | 101 ++++++++++
 tb/tb_bw_seq_mult.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bw_seq_mult.sv
// Iterative signed Baugh-Wooley multiplier: one partial-product row per clock, 2N-bit product.
// Optional BW_EARLY_ZERO_EN: a zero operand at accept completes on the accept edge with p=0.
module bw_seq_mult #(
   parameter int N = 5
) (
   input  logic           clk,
   input  logic           rs,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] p
);

   localparam int unsigned IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   // Baugh-Wooley correction constant folded into the accumulator seed.
   localparam logic [2*N-1:0] ACC_INIT = ((2*N)'(1) << N) | ((2*N)'(1) << (2*N - 1));

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic [IW-1:0]  idx;
   logic [2*N-1:0] acc;

   logic [N-1:0]   pp;
   logic [N-1:0]   row;
   logic [2*N-1:0] addend;
   logic [2*N-1:0] acc_next;

   // Sign-weighted terms are inverted; on the last row the roles swap.
   always_comb begin
      pp = a_r & {N{b_r[idx]}};
      if (idx == LAST)
         row = {pp[N-1], ~pp[N-2:0]};
      else
         row = {~pp[N-1], pp[N-2:0]};
      addend   = {{N{1'b0}}, row} << idx;
      acc_next = acc + addend;
   end

   always_ff @(posedge clk) begin
      if (rs) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         p     <= '0;
         idx   <= '0;
         acc   <= '0;
         a_r   <= '0;
         b_r   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_r <= a;
                  b_r <= b;
                  acc <= ACC_INIT;
                  idx <= '0;
`ifdef BW_EARLY_ZERO_EN
                  if ((a == '0) || (b == '0)) begin
                     p     <= '0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= RUN;
                  end
`else
                  busy  <= 1'b1;
                  state <= RUN;
`endif
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (idx == LAST) begin
                  p     <= acc_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bw_seq_mult.sv
// Scoreboard bench for bw_seq_mult: driver pushes expected product and done cycle, monitor checks.
module tb_bw_seq_mult;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rs = 1'b1;
   logic           start = 1'b0;
   logic [N-1:0]   a = '0;
   logic [N-1:0]   b = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] p;

   bw_seq_mult #(.N(N)) dut (
      .clk  (clk),
      .rs   (rs),
      .start(start),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .p    (p)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*N-1:0] p;
      int unsigned    cyc;
   } exp_t;

   exp_t           q[$];
   logic [2*N-1:0] p_model = '0;
   int unsigned    cyc = 0;
   int             n_checks = 0;
   int             n_fail = 0;
   logic           mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic busy_exp;
         busy_exp = (q.size() > 0) && (cyc < q[0].cyc);
         chk("busy", 64'(busy), 64'(busy_exp));
         if (done === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", 64'(cyc), 64'(e.cyc));
               chk("product", 64'(p), 64'(e.p));
               p_model = e.p;
            end
         end else begin
            chk("p_hold", 64'(p), 64'(p_model));
            if (q.size() > 0 && cyc > q[0].cyc) begin
               n_checks++;
               n_fail++;
               $display("FAIL missing_done: got done=0 expected done=1 at cycle %0d", q[0].cyc);
               void'(q.pop_front());
            end
         end
      end
   end

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] av, input logic [N-1:0] bv);
      logic signed [2*N-1:0] r;
      r = $signed(av) * $signed(bv);
      return r;
   endfunction

   function automatic int unsigned ref_lat(input logic [N-1:0] av, input logic [N-1:0] bv);
`ifdef BW_EARLY_ZERO_EN
      if (av == '0 || bv == '0) return 1;
`endif
      return N + 1;
   endfunction

   task automatic drive_start(input logic [N-1:0] av, input logic [N-1:0] bv, input bit expect_accept);
      exp_t e;
      #1;
      a = av;
      b = bv;
      start = 1'b1;
      if (expect_accept) begin
         e.p = ref_mul(av, bv);
         e.cyc = cyc + ref_lat(av, bv);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
   endtask

   task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (k == 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_wait: got busy=1 expected busy=0 within 50 cycles");
      end
      drive_start(av, bv, 1'b1);
   endtask

   task automatic wait_done();
      int k;
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) break;
      end
      if (k == 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_wait: got done=0 expected done=1 within 50 cycles");
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_p", 64'(p), 64'(0));
      #1;
      rs = 1'b0;
      mon_en = 1'b1;

      issue(N'(-16), N'(-16));
      issue(N'(15), N'(15));
      issue(N'(-16), N'(15));
      issue(N'(-1), N'(1));

      // start in the done cycle of the previous op
      issue(N'(7), N'(7));
      wait_done();
      drive_start(N'(3), N'(-2), 1'b1);

      // start while busy must be ignored
      issue(N'(-9), N'(11));
      @(negedge clk);
      @(negedge clk);
      drive_start(N'(13), N'(-3), 1'b0);

      // reset mid-run aborts with no done
      issue(N'(6), N'(-5));
      @(negedge clk);
      @(negedge clk);
      #1;
      rs = 1'b1;
      @(posedge clk);
      #1;
      rs = 1'b0;
      q.delete();
      p_model = '0;
      repeat (8) @(negedge clk);
      issue(N'(-7), N'(9));

      issue(N'(0), N'(-7));
      issue(N'(5), N'(0));
      issue(N'(-16), N'(-1));

      for (int i = 0; i < 1000; i++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         issue(N'($urandom), N'($urandom));
      end

      for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending results expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
